// File: rtl/fetch_req_ctrl_if.sv
// rtl/fetch_req_ctrl_if.sv - icache request/response handshake bundle
// master: fetch side (drives req_valid/req_addr, sees addr_ok/data_ok)
// slave : icache side
interface fetch_req_ctrl_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req_valid,
        output req_addr,
        input  addr_ok,
        input  data_ok
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output addr_ok,
        output data_ok
    );
endinterface

// File: rtl/fetch_req_ctrl.sv
// rtl/fetch_req_ctrl.sv - instruction fetch request controller with credit and flush tracking
// clk, rst        : clock, synchronous active-high reset
// flush, flush_pc : redirect request and target
// ib_free         : free instruction-buffer slots this cycle
// ic              : icache handshake (req_valid/req_addr out, addr_ok/data_ok in)
// resp_valid/pc/num : zero-latency description of the returning request
// proto_err       : sticky, data_ok seen with nothing outstanding
module fetch_req_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          MAX_OUT  = 2,
    parameter int          IB_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [31:0]           flush_pc,
    input  logic [IB_W:0]         ib_free,
    fetch_req_ctrl_if.master      ic,
    output logic                  resp_valid,
    output logic [31:0]           resp_pc,
    output logic [2:0]            resp_num,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] DEPTH = 3'(MAX_OUT);

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [IB_W:0] reserved_q, reserved_d;
    logic [1:0]    head_q, head_d;
    logic [2:0]    count_q, count_d;
    logic          proto_err_q, proto_err_d;
    logic [3:0]    q_stale_q, q_stale_d;

    // Storage is always 4 entries so 2-bit indices fit exactly; only MAX_OUT are used.
    logic [31:0]   q_pc_q  [4];
    logic [31:0]   q_pc_d  [4];
    logic [2:0]    q_num_q [4];
    logic [2:0]    q_num_d [4];

    logic          req_valid;
    logic [2:0]    num;
    logic          full, empty, credit_ok, push, pop;
    logic [IB_W+1:0] need;
    logic [2:0]    tail_sum, head_sum;
    logic [1:0]    tail_idx;

    assign num       = 3'd4 - {1'b0, pc_q[3:2]};
    assign full      = (count_q == DEPTH);
    assign empty     = (count_q == 3'd0);
    // One extra bit so reserved + num cannot wrap before the compare.
    assign need      = {1'b0, reserved_q} + (IB_W+2)'(num);
    assign credit_ok = ({1'b0, ib_free} >= need);
    assign push      = req_valid && ic.addr_ok;
    assign pop       = ic.data_ok && !empty;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (!flush && req_valid && !ic.addr_ok) state_d = S_HOLD;
            S_HOLD:  if (flush || ic.addr_ok) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: credit is only checked when a new request is first raised.
    always_comb begin
        req_valid = 1'b0;
        case (state_q)
            S_FETCH: req_valid = !full && credit_ok && !flush;
            S_HOLD:  req_valid = !flush;
            default: req_valid = 1'b0;
        endcase
        if (rst) req_valid = 1'b0;
    end

    assign ic.req_valid = req_valid;
    assign ic.req_addr  = pc_q;

    // Queue, PC and credit bookkeeping
    always_comb begin
        tail_sum = {1'b0, head_q} + count_q;
        if (tail_sum >= DEPTH) tail_sum = tail_sum - DEPTH;
        tail_idx = tail_sum[1:0];

        head_sum = {1'b0, head_q} + 3'd1;
        if (head_sum == DEPTH) head_sum = 3'd0;
        head_d = pop ? head_sum[1:0] : head_q;

        count_d = count_q + 3'(push) - 3'(pop);

        reserved_d = reserved_q
                   + (push ? (IB_W+1)'(num) : '0)
                   - (pop  ? (IB_W+1)'(q_num_q[head_q]) : '0);

        pc_d = pc_q;
        if (flush) begin
            pc_d = flush_pc & 32'hffff_fffc;
        end else if (push) begin
            pc_d = {pc_q[31:4] + 28'd1, 4'b0000};
        end

        // Stale entries stay queued so their slots are still reserved until returned.
        q_stale_d = flush ? 4'hf : q_stale_q;
        q_pc_d    = q_pc_q;
        q_num_d   = q_num_q;
        if (push) begin
            q_stale_d[tail_idx] = 1'b0;
            q_pc_d[tail_idx]    = pc_q;
            q_num_d[tail_idx]   = num;
        end

        proto_err_d = proto_err_q | (ic.data_ok & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            reserved_q  <= '0;
            head_q      <= 2'd0;
            count_q     <= 3'd0;
            proto_err_q <= 1'b0;
            q_stale_q   <= 4'h0;
        end else begin
            pc_q        <= pc_d;
            reserved_q  <= reserved_d;
            head_q      <= head_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
            q_stale_q   <= q_stale_d;
        end
    end

    always_ff @(posedge clk) begin
        q_pc_q  <= q_pc_d;
        q_num_q <= q_num_d;
    end

    assign resp_valid = pop && !q_stale_q[head_q] && !flush && !rst;
    assign resp_pc    = q_pc_q[head_q];
    assign resp_num   = q_num_q[head_q];
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// tb/tb_fetch_req_ctrl.sv - self-checking bench for fetch_req_ctrl
module tb_fetch_req_ctrl;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int          MAX_OUT  = 2;
    localparam int          IB_W     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [4:0]  ib_free = 5'd16;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic [2:0]  resp_num;
    logic        proto_err;

    always #5 clk = ~clk;

    fetch_req_ctrl_if ic ();

    initial begin
        ic.addr_ok = 1'b0;
        ic.data_ok = 1'b0;
    end

    fetch_req_ctrl #(
        .RESET_PC (RESET_PC),
        .MAX_OUT  (MAX_OUT),
        .IB_W     (IB_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .ib_free    (ib_free),
        .ic         (ic),
        .resp_valid (resp_valid),
        .resp_pc    (resp_pc),
        .resp_num   (resp_num),
        .proto_err  (proto_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: outstanding requests as a queue, credit as a sum over it.
    typedef struct {
        logic [31:0] pc;
        int          num;
        bit          stale;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_started = 0;
    bit          m_holding = 0;
    bit          m_perr = 0;

    task automatic step(input bit r, input bit f, input logic [31:0] fpc,
                        input logic [4:0] fr, input bit aok, input bit dok, input bit mchk);
        int   res;
        int   n;
        bit   e_rv;
        bit   pop;
        bit   e_respv;
        ent_t e;
        @(negedge clk);
        rst = r; flush = f; flush_pc = fpc; ib_free = fr;
        ic.addr_ok = aok; ic.data_ok = dok;
        #1;
        res = 0;
        foreach (mq[i]) res += mq[i].num;
        n = 4 - int'(m_pc[3:2]);
        e_rv = !r && m_started && !f &&
               (m_holding || (mq.size() < MAX_OUT && int'(fr) >= res + n));
        pop = dok && (mq.size() > 0);
        e_respv = 1'b0;
        if (pop && !r) e_respv = !mq[0].stale && !f;
        if (mchk) begin
            chk("req_valid", 32'(ic.req_valid), 32'(e_rv));
            chk("req_addr", ic.req_addr, m_pc);
            chk("resp_valid", 32'(resp_valid), 32'(e_respv));
            if (pop && !r) begin
                chk("resp_pc", resp_pc, mq[0].pc);
                chk("resp_num", 32'(resp_num), 32'(n_of(mq[0])));
            end
            chk("proto_err", 32'(proto_err), 32'(m_perr));
        end
        if (r) begin
            mq.delete();
            m_pc = RESET_PC; m_started = 0; m_holding = 0; m_perr = 0;
        end else begin
            if (dok) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_perr = 1;
            end
            if (f) begin
                foreach (mq[i]) mq[i].stale = 1;
                m_pc = {fpc[31:2], 2'b00};
                m_holding = 0;
            end else if (e_rv && aok) begin
                e.pc = m_pc; e.num = n; e.stale = 0;
                mq.push_back(e);
                m_pc = ((m_pc >> 4) + 32'd1) << 4;
                m_holding = 0;
            end else if (e_rv) begin
                m_holding = 1;
            end
            m_started = 1;
        end
    endtask

    function automatic int n_of(input ent_t e);
        return e.num;
    endfunction

    typedef struct {
        bit          r, f;
        logic [31:0] fpc;
        logic [4:0]  ibf;
        bit          aok, dok;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_respv;
        logic [31:0] e_rpc;
        logic [2:0]  e_rnum;
        bit          e_perr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, bit f, logic [31:0] fpc, logic [4:0] ibf, bit aok, bit dok,
                                bit rv, logic [31:0] addr, bit rsv, logic [31:0] rpc,
                                logic [2:0] rnum, bit perr);
        vec_t v;
        v.r = r; v.f = f; v.fpc = fpc; v.ibf = ibf; v.aok = aok; v.dok = dok;
        v.e_rv = rv; v.e_addr = addr; v.e_respv = rsv; v.e_rpc = rpc;
        v.e_rnum = rnum; v.e_perr = perr;
        return v;
    endfunction

    bit          rr, rf, ra, rd;
    logic [31:0] rfpc;
    logic [4:0]  rib;
    logic [31:0] held_addr;

    initial begin
        //        r f fpc           ib aok dok  rv addr          rsv rpc           num perr
        vt.push_back(mk(1,0,32'h0,        16,1,0, 0,32'h1c00_0000,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,        16,1,0, 0,32'h1c00_0000,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,        16,1,0, 1,32'h1c00_0000,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,        16,1,0, 1,32'h1c00_0010,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,        16,1,0, 0,32'h1c00_0020,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,        16,1,1, 0,32'h1c00_0020,1,32'h1c00_0000,4,0));
        vt.push_back(mk(0,0,32'h0,        16,1,0, 1,32'h1c00_0020,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,        16,1,1, 0,32'h1c00_0030,1,32'h1c00_0010,4,0));
        vt.push_back(mk(0,0,32'h0,        16,0,1, 1,32'h1c00_0030,1,32'h1c00_0020,4,0));
        vt.push_back(mk(0,1,32'h1c00_0009,16,1,0, 0,32'h1c00_0030,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,         1,1,0, 0,32'h1c00_0008,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,         2,1,0, 1,32'h1c00_0008,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,         2,1,1, 0,32'h1c00_0010,1,32'h1c00_0008,2,0));
        vt.push_back(mk(0,0,32'h0,         3,1,0, 0,32'h1c00_0010,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,         4,1,0, 1,32'h1c00_0010,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,         4,1,1, 0,32'h1c00_0020,1,32'h1c00_0010,4,0));
        vt.push_back(mk(0,0,32'h0,         4,0,1, 1,32'h1c00_0020,0,32'h0,        0,0));
        vt.push_back(mk(0,0,32'h0,         0,1,0, 1,32'h1c00_0020,0,32'h0,        0,1));
        vt.push_back(mk(1,0,32'h0,         0,1,0, 0,32'h1c00_0030,0,32'h0,        0,1));
        vt.push_back(mk(0,0,32'h0,        16,0,0, 0,32'h1c00_0000,0,32'h0,        0,0));

        step(1, 0, 32'h0, 5'd16, 0, 0, 0);

        foreach (vt[i]) begin
            step(vt[i].r, vt[i].f, vt[i].fpc, vt[i].ibf, vt[i].aok, vt[i].dok, 1);
            chk($sformatf("t%0d_req_valid", i), 32'(ic.req_valid), 32'(vt[i].e_rv));
            chk($sformatf("t%0d_req_addr", i), ic.req_addr, vt[i].e_addr);
            chk($sformatf("t%0d_resp_valid", i), 32'(resp_valid), 32'(vt[i].e_respv));
            if (vt[i].e_respv) begin
                chk($sformatf("t%0d_resp_pc", i), resp_pc, vt[i].e_rpc);
                chk($sformatf("t%0d_resp_num", i), 32'(resp_num), 32'(vt[i].e_rnum));
            end
            chk($sformatf("t%0d_proto_err", i), 32'(proto_err), 32'(vt[i].e_perr));
        end

        // HOLD stability: three stalled cycles, then a single accept.
        step(1, 0, 32'h0, 5'd16, 0, 0, 1);
        step(0, 0, 32'h0, 5'd16, 0, 0, 1);
        held_addr = 32'h1c00_0000;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 32'h0, (k == 0) ? 5'd16 : 5'd0, 0, 0, 1);
            chk("hold_req_valid", 32'(ic.req_valid), 32'd1);
            chk("hold_req_addr", ic.req_addr, held_addr);
        end
        step(0, 0, 32'h0, 5'd0, 1, 0, 1);
        step(0, 0, 32'h0, 5'd0, 0, 1, 1);
        chk("hold_one_push_resp", 32'(resp_valid), 32'd1);
        step(0, 0, 32'h0, 5'd0, 0, 1, 1);
        step(0, 0, 32'h0, 5'd0, 0, 0, 1);
        chk("hold_one_push_perr", 32'(proto_err), 32'd1);

        // Flush with two requests outstanding.
        step(1, 0, 32'h0, 5'd16, 0, 0, 1);
        chk("reset_clears_perr", 32'(proto_err), 32'd1);
        step(0, 0, 32'h0, 5'd16, 1, 0, 1);
        chk("after_reset_perr", 32'(proto_err), 32'd0);
        step(0, 0, 32'h0, 5'd16, 1, 0, 1);
        step(0, 0, 32'h0, 5'd16, 1, 0, 1);
        step(0, 1, 32'h1c00_1000, 5'd16, 1, 0, 1);
        chk("flush_req_valid", 32'(ic.req_valid), 32'd0);
        step(0, 0, 32'h0, 5'd16, 0, 1, 1);
        chk("stale_resp0", 32'(resp_valid), 32'd0);
        step(0, 0, 32'h0, 5'd16, 0, 1, 1);
        chk("stale_resp1", 32'(resp_valid), 32'd0);
        step(0, 0, 32'h0, 5'd16, 1, 0, 1);
        chk("redirect_addr", ic.req_addr, 32'h1c00_1000);
        chk("redirect_valid", 32'(ic.req_valid), 32'd1);
        step(0, 0, 32'h0, 5'd16, 0, 1, 1);
        chk("redirect_resp_valid", 32'(resp_valid), 32'd1);
        chk("redirect_resp_pc", resp_pc, 32'h1c00_1000);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            rr   = ($urandom_range(0, 63) == 0);
            rf   = ($urandom_range(0, 15) == 0);
            rfpc = $urandom;
            rib  = 5'($urandom_range(0, 31));
            ra   = 1'($urandom_range(0, 1));
            rd   = ($urandom_range(0, 9) < 4);
            step(rr, rf, rfpc, rib, ra, rd, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
